// File: rtl/alarm_pkg.sv
// Shared state encoding and default timing parameters for the alarm controller.
package alarm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARMED  = 3'd1,
      ST_RING   = 3'd2,
      ST_SNOOZE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int unsigned DEF_SNOOZE_SEC = 300;
   localparam int unsigned DEF_RING_SEC   = 60;
   localparam int unsigned DEF_MAX_SNOOZE = 3;

endpackage

// File: rtl/alarm_ctrl_edge_det.sv
// Rising-edge detector for a debounced button level; a held level never re-fires.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic i_level,
   output logic o_rise_c
);

   logic r_prev;

   always_ff @(posedge clk) begin
      if (rst) r_prev <= 1'b0;
      else     r_prev <= i_level;
   end

   assign o_rise_c = i_level & ~r_prev;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: arm, ring on time match, snooze/stop handling, beep phase.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int unsigned SNOOZE_SEC = DEF_SNOOZE_SEC,
   parameter int unsigned RING_SEC   = DEF_RING_SEC,
   parameter int unsigned MAX_SNOOZE = DEF_MAX_SNOOZE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1hz,
   input  logic        alarm_en,
   input  logic        load_active,
   input  logic [15:0] clock_time,
   input  logic [15:0] alarm_time,
   input  logic        snooze_btn,
   input  logic        stop_btn,
   output logic        ringing,
   output logic        buzzer,
   output logic        snooze_active,
   output logic [1:0]  snooze_cnt,
   output logic [2:0]  state
);

   localparam int unsigned MAX_SEC = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
   localparam int unsigned TW      = $clog2(MAX_SEC + 1);

   state_t        r_state;
   logic          r_ringing;
   logic          r_buzzer;
   logic          r_phase;
   logic          r_snooze_active;
   logic [1:0]    r_snooze_cnt;
   logic [TW-1:0] r_ring_tmr;
   logic [TW-1:0] r_snz_tmr;

   logic w_match;
   logic w_snooze_rise;
   logic w_stop_rise;

   edge_det u_snooze_edge (
      .clk      (clk),
      .rst      (rst),
      .i_level  (snooze_btn),
      .o_rise_c (w_snooze_rise)
   );

   edge_det u_stop_edge (
      .clk      (clk),
      .rst      (rst),
      .i_level  (stop_btn),
      .o_rise_c (w_stop_rise)
   );

   assign w_match = (clock_time == alarm_time) && !load_active;

   // Outputs are updated together with each transition so they track the next state.
   always_ff @(posedge clk) begin
      if (rst || !alarm_en) begin
         r_state         <= rst ? ST_IDLE : ((r_state == ST_IDLE) ? ST_IDLE : ST_IDLE);
         r_ringing       <= 1'b0;
         r_buzzer        <= 1'b0;
         r_phase         <= 1'b0;
         r_snooze_active <= 1'b0;
         r_snooze_cnt    <= 2'd0;
         r_ring_tmr      <= '0;
         r_snz_tmr       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= ST_ARMED;
            ST_ARMED: begin
               if (w_match) begin
                  r_state    <= ST_RING;
                  r_ringing  <= 1'b1;
                  r_ring_tmr <= '0;
                  r_phase    <= 1'b0;
                  r_buzzer   <= 1'b0;
               end
            end
            ST_RING: begin
               if (w_stop_rise) begin
                  r_state   <= ST_DONE;
                  r_ringing <= 1'b0;
                  r_phase   <= 1'b0;
                  r_buzzer  <= 1'b0;
               end else if (w_snooze_rise && (r_snooze_cnt < 2'(MAX_SNOOZE))) begin
                  r_state         <= ST_SNOOZE;
                  r_ringing       <= 1'b0;
                  r_phase         <= 1'b0;
                  r_buzzer        <= 1'b0;
                  r_snooze_active <= 1'b1;
                  r_snooze_cnt    <= r_snooze_cnt + 2'(1);
                  r_snz_tmr       <= '0;
               end else if (tick_1hz) begin
                  if (r_ring_tmr >= TW'(RING_SEC - 1)) begin
                     r_state   <= ST_DONE;
                     r_ringing <= 1'b0;
                     r_phase   <= 1'b0;
                     r_buzzer  <= 1'b0;
                  end else begin
                     r_ring_tmr <= r_ring_tmr + TW'(1);
                     r_phase    <= ~r_phase;
                     r_buzzer   <= ~r_phase;
                  end
               end
            end
            ST_SNOOZE: begin
               if (w_stop_rise) begin
                  r_state         <= ST_DONE;
                  r_snooze_active <= 1'b0;
               end else if (tick_1hz) begin
                  if (r_snz_tmr >= TW'(SNOOZE_SEC - 1)) begin
                     r_state         <= ST_RING;
                     r_snooze_active <= 1'b0;
                     r_ringing       <= 1'b1;
                     r_ring_tmr      <= '0;
                     r_phase         <= 1'b0;
                     r_buzzer        <= 1'b0;
                  end else begin
                     r_snz_tmr <= r_snz_tmr + TW'(1);
                  end
               end
            end
            ST_DONE: begin
               // Wait for the matching minute to pass so the alarm cannot retrigger.
               if (!w_match) begin
                  r_state      <= ST_ARMED;
                  r_snooze_cnt <= 2'd0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ringing       = r_ringing;
   assign buzzer        = r_buzzer;
   assign snooze_active = r_snooze_active;
   assign snooze_cnt    = r_snooze_cnt;
   assign state         = 3'(r_state);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with shortened timing parameters.
module tb_alarm_ctrl;
   import alarm_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick_1hz;
   logic        alarm_en;
   logic        load_active;
   logic [15:0] clock_time;
   logic [15:0] alarm_time;
   logic        snooze_btn;
   logic        stop_btn;
   logic        ringing;
   logic        buzzer;
   logic        snooze_active;
   logic [1:0]  snooze_cnt;
   logic [2:0]  state;

   int n_checks = 0;
   int n_fail   = 0;

   alarm_ctrl #(.SNOOZE_SEC(3), .RING_SEC(4), .MAX_SNOOZE(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .tick_1hz      (tick_1hz),
      .alarm_en      (alarm_en),
      .load_active   (load_active),
      .clock_time    (clock_time),
      .alarm_time    (alarm_time),
      .snooze_btn    (snooze_btn),
      .stop_btn      (stop_btn),
      .ringing       (ringing),
      .buzzer        (buzzer),
      .snooze_active (snooze_active),
      .snooze_cnt    (snooze_cnt),
      .state         (state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance n clock edges; inputs change and outputs are sampled 1ns after the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick();
      tick_1hz = 1'b1;
      step(1);
      tick_1hz = 1'b0;
   endtask

   initial begin
      rst = 1'b1; tick_1hz = 1'b0; alarm_en = 1'b0; load_active = 1'b0;
      clock_time = 16'h0629; alarm_time = 16'h0630; snooze_btn = 1'b0; stop_btn = 1'b0;
      step(2);
      check_eq("rst_state", 32'(state), 32'(ST_IDLE));
      check_eq("rst_outs", {ringing, buzzer, snooze_active, snooze_cnt}, 32'd0);

      // Arm and trigger on the minute match.
      rst = 1'b0; alarm_en = 1'b1;
      step(1);
      check_eq("arm", 32'(state), 32'(ST_ARMED));
      step(2);
      check_eq("armed_nomatch", {state, ringing}, {ST_ARMED, 1'b0});
      clock_time = 16'h0630;
      step(1);
      check_eq("trig_ringing", 32'(ringing), 32'd1);
      check_eq("trig_state", 32'(state), 32'(ST_RING));
      check_eq("trig_buzz0", 32'(buzzer), 32'd0);

      // Beep phase toggles per tick; fourth tick times out.
      tick();
      check_eq("buzz_t1", 32'(buzzer), 32'd1);
      step(1);
      check_eq("buzz_hold", 32'(buzzer), 32'd1);
      tick();
      check_eq("buzz_t2", 32'(buzzer), 32'd0);
      tick();
      check_eq("buzz_t3", {state, buzzer}, {ST_RING, 1'b1});
      tick();
      check_eq("timeout", {state, ringing, buzzer}, {ST_DONE, 1'b0, 1'b0});
      step(3);
      check_eq("done_hold", 32'(state), 32'(ST_DONE));
      clock_time = 16'h0631;
      step(1);
      check_eq("done_rearm", 32'(state), 32'(ST_ARMED));

      // Snooze twice, third snooze ignored.
      clock_time = 16'h0630;
      step(1);
      check_eq("ring2", 32'(state), 32'(ST_RING));
      snooze_btn = 1'b1;
      step(1);
      snooze_btn = 1'b0;
      check_eq("snz1", {state, snooze_active, ringing, snooze_cnt}, {ST_SNOOZE, 1'b1, 1'b0, 2'd1});
      tick(); tick();
      check_eq("snz1_wait", {state, buzzer}, {ST_SNOOZE, 1'b0});
      tick();
      check_eq("snz1_back", {state, snooze_active, ringing}, {ST_RING, 1'b0, 1'b1});
      snooze_btn = 1'b1;
      step(1);
      snooze_btn = 1'b0;
      check_eq("snz2", {state, snooze_cnt}, {ST_SNOOZE, 2'd2});
      tick(); tick(); tick();
      check_eq("snz2_back", 32'(state), 32'(ST_RING));
      snooze_btn = 1'b1;
      step(1);
      snooze_btn = 1'b0;
      check_eq("snz3_ignored", {state, snooze_cnt, ringing}, {ST_RING, 2'd2, 1'b1});

      // Stop keeps the count in DONE; count clears on leaving DONE.
      stop_btn = 1'b1;
      step(1);
      stop_btn = 1'b0;
      check_eq("stop", {state, snooze_cnt, ringing}, {ST_DONE, 2'd2, 1'b0});
      clock_time = 16'h0631;
      step(1);
      check_eq("cnt_clear", {state, snooze_cnt}, {ST_ARMED, 2'd0});

      // Simultaneous snooze and stop: stop wins; held stop has no further effect.
      clock_time = 16'h0630;
      step(1);
      snooze_btn = 1'b1;
      step(1);
      snooze_btn = 1'b0;
      tick(); tick(); tick();
      check_eq("pre_both", {state, snooze_cnt}, {ST_RING, 2'd1});
      snooze_btn = 1'b1; stop_btn = 1'b1;
      step(1);
      snooze_btn = 1'b0;
      check_eq("both_edges", {state, snooze_cnt}, {ST_DONE, 2'd1});
      clock_time = 16'h0631;
      step(1);
      clock_time = 16'h0630;
      step(1);
      step(2);
      check_eq("stop_held", {state, ringing}, {ST_RING, 1'b1});
      stop_btn = 1'b0;

      // load_active suppresses arming trigger only; alarm_en=0 forces IDLE.
      alarm_en = 1'b0;
      step(1);
      check_eq("en_off", {state, ringing}, {ST_IDLE, 1'b0});
      load_active = 1'b1; alarm_en = 1'b1;
      step(3);
      check_eq("load_suppress", {state, ringing}, {ST_ARMED, 1'b0});
      load_active = 1'b0;
      step(1);
      check_eq("load_release", 32'(state), 32'(ST_RING));
      snooze_btn = 1'b1;
      step(1);
      snooze_btn = 1'b0;
      load_active = 1'b1;
      step(1);
      check_eq("load_in_snz", {state, snooze_cnt}, {ST_SNOOZE, 2'd1});
      alarm_en = 1'b0;
      step(1);
      check_eq("en_off_snz", {state, snooze_active, snooze_cnt}, {ST_IDLE, 1'b0, 2'd0});
      load_active = 1'b0;

      // Reset mid-RING aborts; recovers to ARMED.
      alarm_en = 1'b1;
      step(2);
      tick();
      check_eq("pre_rst", {state, buzzer}, {ST_RING, 1'b1});
      rst = 1'b1;
      step(1);
      check_eq("rst_mid", {state, ringing, buzzer, snooze_active, snooze_cnt}, {ST_IDLE, 5'd0});
      rst = 1'b0;
      step(1);
      check_eq("rst_rearm", 32'(state), 32'(ST_ARMED));

      // Out-of-range BCD is compared as-is.
      alarm_time = 16'hFFFF; clock_time = 16'hFFFF;
      step(1);
      check_eq("bcd_raw", {state, ringing}, {ST_RING, 1'b1});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter SNOOZE_SEC, default 300, snooze duration in tick_1hz pulses.
REQ-002 Parameter RING_SEC, default 60, auto-stop timeout in tick_1hz pulses while ringing.
REQ-003 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 tick_1hz  in  1  one-clk-wide pulse, once per second, synchronous to clk.
REQ-007 alarm_en  in  1  alarm arm switch; 0 forces IDLE.
REQ-008 load_active  in  1  clock or alarm load in progress; suppresses triggering.
REQ-009 clock_time  in  16  BCD HH:MM {hr1,hr0,min1,min0}, 4 bits per digit.
REQ-010 alarm_time  in  16  BCD HH:MM, same format.
REQ-011 snooze_btn  in  1  debounced level; acted on at rising edge only.
REQ-012 stop_btn  in  1  debounced level; acted on at rising edge only.
REQ-013 ringing  out  1  alarm sounding.
REQ-014 buzzer  out  1  ringing AND beep phase.
REQ-015 snooze_active  out  1  in SNOOZE state.
REQ-016 snooze_cnt  out  2  snoozes used in current event.
REQ-017 state  out  3  current FSM state encoding, for LEDs/debug.

Function
REQ-018 FSM states IDLE, ARMED, RING, SNOOZE, DONE; all outputs registered.
REQ-019 IDLE -> ARMED when alarm_en=1; any state -> IDLE on the clk after alarm_en=0 sampled, clearing counters.
REQ-020 match = (clock_time == alarm_time) AND NOT load_active, full 16-bit compare.
REQ-021 ARMED -> RING on the clk after match sampled 1; ringing=1 from that clk edge (1-cycle latency).
REQ-022 RING: ring timer clears on entry, increments per tick_1hz; at RING_SEC ticks -> DONE.
REQ-023 RING + stop_btn rising edge -> DONE; stop wins over simultaneous snooze edge.
REQ-024 RING + snooze_btn rising edge with snooze_cnt < MAX_SNOOZE -> SNOOZE, snooze_cnt+1; with snooze_cnt = MAX_SNOOZE snooze edge ignored.
REQ-025 SNOOZE: snooze timer clears on entry, increments per tick_1hz; at SNOOZE_SEC ticks -> RING (ring timer restarted).
REQ-026 SNOOZE + stop_btn rising edge -> DONE.
REQ-027 DONE -> ARMED once match=0 (prevents retrigger in same minute); snooze_cnt clears on leaving DONE.
REQ-028 Button edges detected by a registered previous value; held level never re-fires.
REQ-029 beep phase toggles on each tick_1hz while in RING, cleared on RING entry; buzzer = ringing AND phase.
REQ-030 Timers sized ceil(log2(max(SNOOZE_SEC,RING_SEC)+1)) bits; saturate, never wrap.
REQ-031 load_active during SNOOZE or RING has no effect; only ARMED triggering is suppressed.
REQ-032 Out-of-range BCD inputs are compared as-is, no validity checking.

Reset
REQ-033 rst=1 at posedge clk: state=IDLE, ringing=0, buzzer=0, snooze_active=0, snooze_cnt=0, timers=0, phase=0, edge registers=0.
REQ-034 rst mid-RING or mid-SNOOZE aborts immediately; after release, IDLE -> ARMED next clk if alarm_en=1.
REQ-035 rst has priority over all other inputs.

Structure
REQ-036 Shared package alarm_pkg holds the state encoding constants and default SNOOZE_SEC, RING_SEC, MAX_SNOOZE.
REQ-037 One sub-module edge_det (rising-edge pulse, sync reset) instantiated for snooze_btn and stop_btn.
REQ-038 No clock division inside; tick_1hz supplied from the existing divider as a clk-domain pulse.

Verification (RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2 for sim)
REQ-039 alarm_en=1, alarm_time=0x0630, clock_time steps 0x0629->0x0630 -> ringing=1 exactly one clk after compare; state=RING.
REQ-040 RING, 4 tick_1hz pulses, no buttons -> DONE, ringing=0; clock_time held 0x0630 -> stays DONE; ->0x0631 -> ARMED.
REQ-041 RING, snooze edge -> SNOOZE, snooze_cnt=1; 3 ticks -> RING; snooze again -> cnt=2; third snooze ignored, still RING.
REQ-042 RING, snooze_btn and stop_btn rise same clk -> DONE, snooze_cnt unchanged; stop_btn held high further -> no effect.
REQ-043 match with load_active=1 -> stays ARMED; alarm_en=0 during SNOOZE -> IDLE, snooze_cnt=0 next clk.
REQ-044 rst pulse mid-RING -> all outputs 0, IDLE; buzzer toggles once per tick only while RING.
